// File: rtl/fp_align_pipe_if.sv
// fp_align_pipe_if: handshake and data bus for the exponent-alignment pipeline.
//
// Carries the upstream beat (in_*), the downstream beat (out_*) and both
// valid/ready pairs.
//   slave  modport : the alignment stage (consumes in_*, produces out_*)
//   master modport : the surrounding datapath / testbench
//
// Operand layout (OP_W = 1 + EXP_W + MAN_W):
//   [OP_W-1] sign, [OP_W-2:MAN_W] biased exponent, [MAN_W-1:0] mantissa
interface fp_align_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 27,
    parameter int TAG_W  = 8,
    parameter int SIDE_W = 36
);
    localparam int OP_W = 1 + EXP_W + MAN_W;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_idle;
    logic [OP_W-1:0]   in_c;
    logic [OP_W-1:0]   in_z;
    logic [SIDE_W-1:0] in_side;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_idle;
    logic [OP_W-1:0]   out_c;
    logic [OP_W-1:0]   out_z;
    logic [SIDE_W-1:0] out_side;
    logic [TAG_W-1:0]  out_tag;
    logic              out_sat;

    modport slave (
        input  in_valid, in_idle, in_c, in_z, in_side, in_tag, out_ready,
        output in_ready, out_valid, out_idle, out_c, out_z, out_side, out_tag, out_sat
    );

    modport master (
        output in_valid, in_idle, in_c, in_z, in_side, in_tag, out_ready,
        input  in_ready, out_valid, out_idle, out_c, out_z, out_side, out_tag, out_sat
    );
endinterface

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage elastic exponent-alignment stage for the
// floating-point adder path of the CORDIC datapath.
//
// Stage 1 compares the biased exponents of C and Z and registers the
// distance d = |Ec - Ez| together with which operand is the smaller one.
// Stage 2 right-shifts the smaller operand's mantissa by d, folding every
// bit shifted out into bit 0 (sticky), and gives it the larger exponent.
// Distances of MAN_W or more collapse the mantissa to {0, |m} and raise
// out_sat. In put_idle (in_idle = 2'b10) both operands pass bit-exact.
// Sideband, tag and idle code ride along untouched.
//
// Ports:
//   clock      : sole clock, rising edge
//   reset_n    : synchronous active-low reset; clears both stages and outputs
//   bus        : fp_align_pipe_if.slave (in_* beat, out_* beat, valid/ready)
//   sat_count  : [15:0] saturating count of saturated output handshakes,
//                present only when ALIGN_SAT_COUNT_EN is defined
//
// Optional feature macro: ALIGN_SAT_COUNT_EN
module fp_align_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 27,
    parameter int TAG_W  = 8,
    parameter int SIDE_W = 36
) (
    input  logic        clock,
    input  logic        reset_n,
    fp_align_pipe_if.slave bus
`ifdef ALIGN_SAT_COUNT_EN
    ,
    output logic [15:0] sat_count
`endif
);
    localparam int          OP_W     = 1 + EXP_W + MAN_W;
    localparam logic [31:0] MAN_W_U  = 32'(MAN_W);
    localparam logic [1:0]  IDLE_PUT = 2'b10;

    // Handshake
    logic              en_s;

    // Stage 1 registers
    logic              s1_valid_r;
    logic [1:0]        s1_idle_r;
    logic [OP_W-1:0]   s1_c_r;
    logic [OP_W-1:0]   s1_z_r;
    logic [SIDE_W-1:0] s1_side_r;
    logic [TAG_W-1:0]  s1_tag_r;
    logic [EXP_W-1:0]  s1_d_r;
    logic              s1_z_small_r;

    // Output registers
    logic              out_valid_r;
    logic [1:0]        out_idle_r;
    logic [OP_W-1:0]   out_c_r;
    logic [OP_W-1:0]   out_z_r;
    logic [SIDE_W-1:0] out_side_r;
    logic [TAG_W-1:0]  out_tag_r;
    logic              out_sat_r;

    // Stage 1 combinational
    logic [EXP_W-1:0]  ec_s;
    logic [EXP_W-1:0]  ez_s;
    logic [EXP_W-1:0]  d_s;
    logic              z_small_s;

    // Stage 2 combinational
    logic [OP_W-1:0]   small_op_s;
    logic [EXP_W-1:0]  big_exp_s;
    logic [MAN_W-1:0]  small_man_s;
    logic [MAN_W-1:0]  shifted_s;
    logic [MAN_W-1:0]  lost_mask_s;
    logic [MAN_W-1:0]  aligned_man_s;
    logic [OP_W-1:0]   aligned_op_s;
    logic              sat_s;
    logic [OP_W-1:0]   c_next_s;
    logic [OP_W-1:0]   z_next_s;
    logic              sat_next_s;

    // Whole pipe moves as one: it advances whenever the output slot is free or being taken.
    assign en_s         = !out_valid_r || bus.out_ready;
    assign bus.in_ready = en_s;

    assign bus.out_valid = out_valid_r;
    assign bus.out_idle  = out_idle_r;
    assign bus.out_c     = out_c_r;
    assign bus.out_z     = out_z_r;
    assign bus.out_side  = out_side_r;
    assign bus.out_tag   = out_tag_r;
    assign bus.out_sat   = out_sat_r;

    // Exponent compare: ties make C the small operand (shifted by zero, so unchanged).
    always_comb begin
        ec_s      = bus.in_c[OP_W-2:MAN_W];
        ez_s      = bus.in_z[OP_W-2:MAN_W];
        z_small_s = 1'b0;
        d_s       = {EXP_W{1'b0}};
        if (ec_s > ez_s) begin
            z_small_s = 1'b1;
            d_s       = ec_s - ez_s;
        end else begin
            z_small_s = 1'b0;
            d_s       = ez_s - ec_s;
        end
    end

    // Alignment shift with sticky collapse, then put_idle bypass selection.
    always_comb begin
        small_op_s = s1_c_r;
        big_exp_s  = s1_z_r[OP_W-2:MAN_W];
        if (s1_z_small_r) begin
            small_op_s = s1_z_r;
            big_exp_s  = s1_c_r[OP_W-2:MAN_W];
        end else begin
            small_op_s = s1_c_r;
            big_exp_s  = s1_z_r[OP_W-2:MAN_W];
        end

        small_man_s = small_op_s[MAN_W-1:0];
        sat_s       = (32'(s1_d_r) >= MAN_W_U);
        // Ones in the positions that fall off the right end for a shift of d.
        lost_mask_s = ~({MAN_W{1'b1}} << s1_d_r);
        shifted_s   = small_man_s >> s1_d_r;

        if (sat_s) begin
            aligned_man_s = {{(MAN_W-1){1'b0}}, |small_man_s};
        end else begin
            aligned_man_s = {shifted_s[MAN_W-1:1],
                             shifted_s[0] | (|(small_man_s & lost_mask_s))};
        end
        aligned_op_s = {small_op_s[OP_W-1], big_exp_s, aligned_man_s};

        c_next_s   = s1_c_r;
        z_next_s   = s1_z_r;
        sat_next_s = 1'b0;
        case (s1_idle_r)
            IDLE_PUT: begin
                c_next_s   = s1_c_r;
                z_next_s   = s1_z_r;
                sat_next_s = 1'b0;
            end
            default: begin
                // 2'b11 is handled exactly like no_idle.
                if (s1_z_small_r) begin
                    c_next_s = s1_c_r;
                    z_next_s = aligned_op_s;
                end else begin
                    c_next_s = aligned_op_s;
                    z_next_s = s1_z_r;
                end
                sat_next_s = sat_s;
            end
        endcase
    end

    // Pipeline registers: both stages load together on en_s, otherwise hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_r   <= 1'b0;
            s1_idle_r    <= 2'b00;
            s1_c_r       <= {OP_W{1'b0}};
            s1_z_r       <= {OP_W{1'b0}};
            s1_side_r    <= {SIDE_W{1'b0}};
            s1_tag_r     <= {TAG_W{1'b0}};
            s1_d_r       <= {EXP_W{1'b0}};
            s1_z_small_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_idle_r   <= 2'b00;
            out_c_r      <= {OP_W{1'b0}};
            out_z_r      <= {OP_W{1'b0}};
            out_side_r   <= {SIDE_W{1'b0}};
            out_tag_r    <= {TAG_W{1'b0}};
            out_sat_r    <= 1'b0;
        end else if (en_s) begin
            s1_valid_r   <= bus.in_valid;
            s1_idle_r    <= bus.in_idle;
            s1_c_r       <= bus.in_c;
            s1_z_r       <= bus.in_z;
            s1_side_r    <= bus.in_side;
            s1_tag_r     <= bus.in_tag;
            s1_d_r       <= d_s;
            s1_z_small_r <= z_small_s;
            out_valid_r  <= s1_valid_r;
            out_idle_r   <= s1_idle_r;
            out_c_r      <= c_next_s;
            out_z_r      <= z_next_s;
            out_side_r   <= s1_side_r;
            out_tag_r    <= s1_tag_r;
            out_sat_r    <= sat_next_s;
        end
    end

`ifdef ALIGN_SAT_COUNT_EN
    logic [15:0] sat_count_r;

    assign sat_count = sat_count_r;

    // Count saturated beats as they leave; stick at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sat_count_r <= 16'h0000;
        end else if (out_valid_r && bus.out_ready && out_sat_r && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'd1;
        end
    end
`endif

endmodule
